// File: rtl/alu_mdu_seq_pkg.sv
// Shared encodings for the ALU and the multiply/divide sequencer that borrows it.
package alu_mdu_seq_pkg;

  // ALU control encodings, {funct7[5], funct3} style
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  // One bit of result per step, so the step count equals the operand width
  localparam int unsigned MDU_STEPS = 32;

  typedef enum logic [1:0] {
    MDU_MUL  = 2'b00,
    MDU_DIVU = 2'b01,
    MDU_REMU = 2'b10,
    MDU_RSVD = 2'b11
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL_STEP = 3'd1,
    ST_DIV_STEP = 3'd2,
    ST_DIV_SUB  = 3'd3,
    ST_DONE     = 3'd4
  } mdu_state_e;

endpackage

// File: rtl/alu_mdu_seq.sv
// Multi-cycle MUL/DIVU/REMU sequencer that drives the shared combinational ALU
// one operation per cycle: shift-and-add multiply, restoring divide.
module alu_mdu_seq
  import alu_mdu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      req_op_i,
  input  logic [XLEN-1:0] req_a_i,
  input  logic [XLEN-1:0] req_b_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_data_o,
  output logic            busy_o,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  output logic [3:0]      aluctrl_ctrl_o,
  input  logic [XLEN-1:0] alu_out_i
);

  mdu_state_e      state, state_n;
  mdu_op_e         op_q, op_n;
  logic [XLEN-1:0] acc, acc_n;
  logic [XLEN-1:0] mc, mc_n;
  logic [XLEN-1:0] mp, mp_n;
  logic [XLEN-1:0] rem, rem_n;
  logic [XLEN-1:0] quo, quo_n;
  logic [XLEN-1:0] dvs, dvs_n;
  logic [5:0]      cnt, cnt_n;
  logic [XLEN-1:0] data_q, data_n;
  logic [XLEN-1:0] rs;
  logic            bit_done;

  assign req_ready_o = (state == ST_IDLE);
  assign rsp_valid_o = (state == ST_DONE);
  assign busy_o      = (state != ST_IDLE);
  assign rsp_data_o  = data_q;

  // Next-state, datapath updates and ALU requests; the ALU sees zeros unless a step issues an op
  always_comb begin
    state_n        = state;
    op_n           = op_q;
    acc_n          = acc;
    mc_n           = mc;
    mp_n           = mp;
    rem_n          = rem;
    quo_n          = quo;
    dvs_n          = dvs;
    cnt_n          = cnt;
    data_n         = data_q;
    bit_done       = 1'b0;
    alu_a_o        = '0;
    alu_b_o        = '0;
    aluctrl_ctrl_o = ALU_ADD;
    rs             = {rem[XLEN-2:0], quo[XLEN-1]};

    case (state)
      ST_IDLE: begin
        if (req_valid_i) begin
          op_n  = mdu_op_e'(req_op_i);
          dvs_n = req_b_i;
          cnt_n = '0;
          case (mdu_op_e'(req_op_i))
            MDU_MUL: begin
              if (req_b_i == '0) begin
                data_n  = '0;
                state_n = ST_DONE;
              end else begin
                acc_n   = '0;
                mc_n    = req_a_i;
                mp_n    = req_b_i;
                state_n = ST_MUL_STEP;
              end
            end
            MDU_DIVU, MDU_REMU: begin
              if (req_b_i == '0) begin
                data_n  = (mdu_op_e'(req_op_i) == MDU_DIVU) ? '1 : req_a_i;
                state_n = ST_DONE;
              end else begin
                rem_n   = '0;
                quo_n   = req_a_i;
                state_n = ST_DIV_STEP;
              end
            end
            default: begin
              data_n  = '0;
              state_n = ST_DONE;
            end
          endcase
        end
      end

      ST_MUL_STEP: begin
        if (mp[0]) begin
          alu_a_o        = acc;
          alu_b_o        = mc;
          aluctrl_ctrl_o = ALU_ADD;
          acc_n          = alu_out_i;
        end
        mc_n  = mc << 1;
        mp_n  = mp >> 1;
        cnt_n = cnt + 6'd1;
        if ((mp_n == '0) || (cnt_n == 6'(MDU_STEPS))) begin
          data_n  = acc_n;
          state_n = ST_DONE;
        end
      end

      ST_DIV_STEP: begin
        quo_n = {quo[XLEN-2:0], 1'b0};
        if (rem[XLEN-1]) begin
          // Shifted remainder overflowed 32 bits, so it certainly exceeds the divisor
          alu_a_o        = rs;
          alu_b_o        = dvs;
          aluctrl_ctrl_o = ALU_SUB;
          rem_n          = alu_out_i;
          quo_n[0]       = 1'b1;
          bit_done       = 1'b1;
        end else begin
          alu_a_o        = rs;
          alu_b_o        = dvs;
          aluctrl_ctrl_o = ALU_SLTU;
          rem_n          = rs;
          if (alu_out_i[0]) begin
            bit_done = 1'b1;
          end else begin
            state_n = ST_DIV_SUB;
          end
        end
      end

      ST_DIV_SUB: begin
        alu_a_o        = rem;
        alu_b_o        = dvs;
        aluctrl_ctrl_o = ALU_SUB;
        rem_n          = alu_out_i;
        quo_n[0]       = 1'b1;
        bit_done       = 1'b1;
      end

      ST_DONE: begin
        if (rsp_ready_i) begin
          state_n = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if (bit_done) begin
      cnt_n = cnt + 6'd1;
      if (cnt_n == 6'(MDU_STEPS)) begin
        data_n  = (op_q == MDU_REMU) ? rem_n : quo_n;
        state_n = ST_DONE;
      end else begin
        state_n = ST_DIV_STEP;
      end
    end
  end

  // State register; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Operand, partial-result and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= MDU_MUL;
      acc    <= '0;
      mc     <= '0;
      mp     <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      data_q <= '0;
    end else begin
      op_q   <= op_n;
      acc    <= acc_n;
      mc     <= mc_n;
      mp     <= mp_n;
      rem    <= rem_n;
      quo    <= quo_n;
      dvs    <= dvs_n;
      cnt    <= cnt_n;
      data_q <= data_n;
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Scoreboard bench for alu_mdu_seq with a behavioural stand-in for the shared ALU.
module tb_alu_mdu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        busy;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_out;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          compared = 0;
  int          mismatched = 0;
  int          cycle_cnt = 0;
  bit          in_rsp = 1'b0;

  alu_mdu_seq #(.XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_op_i       (req_op),
    .req_a_i        (req_a),
    .req_b_i        (req_b),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_data_o     (rsp_data),
    .busy_o         (busy),
    .alu_a_o        (alu_a),
    .alu_b_o        (alu_b),
    .aluctrl_ctrl_o (alu_ctrl),
    .alu_out_i      (alu_out)
  );

  // Clock generation
  always #5 clk = ~clk;

  // Cycle counter used to measure accept-to-response latency
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Behavioural shared ALU
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_out = alu_a + alu_b;
      4'b1000: alu_out = alu_a - alu_b;
      4'b0011: alu_out = {31'b0, (alu_a < alu_b)};
      default: alu_out = 32'h0;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // Reference result and latency computed from the arithmetic definition
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] d, output int lat);
    logic [32:0] r;
    logic [31:0] q;
    int          n;
    int          h;
    d   = 32'h0;
    lat = 1;
    case (op)
      2'b00: begin
        d = a * b;
        if (b != 0) begin
          h = 0;
          for (int i = 0; i < 32; i++) if (b[i]) h = i;
          lat = h + 2;
        end
      end
      2'b01, 2'b10: begin
        if (b == 0) begin
          d = (op == 2'b01) ? 32'hFFFF_FFFF : a;
        end else begin
          r = 33'h0;
          q = 32'h0;
          n = 0;
          for (int i = 31; i >= 0; i--) begin
            r = {r[31:0], a[i]};
            if (r >= {1'b0, b}) begin
              if (!r[32]) n++;
              r    = r - {1'b0, b};
              q[i] = 1'b1;
            end
          end
          d   = (op == 2'b01) ? q : r[31:0];
          lat = 33 + n;
        end
      end
      default: d = 32'h0;
    endcase
  endfunction

  // Response monitor: pops the scoreboard on a new response and checks it stays stable
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) begin
        if (!in_rsp) begin
          if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_rsp: got data 0x%08h expected no response", rsp_data);
          end else begin
            cur = sb.pop_front();
            checkOutput("rsp_data", rsp_data, cur.data);
            checkOutput("latency", 32'(cycle_cnt - cur.cyc + 1), 32'(cur.lat));
            checkOutput("busy_done", {31'b0, busy}, 32'h1);
          end
          in_rsp = 1'b1;
        end else begin
          checkOutput("rsp_hold", rsp_data, cur.data);
        end
      end else begin
        in_rsp = 1'b0;
      end
    end
  end

  // Drive one request from a negedge with req_ready high, then scramble the inputs
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] d;
    int          lat;
    checkOutput("ready_idle", {31'b0, req_ready}, 32'h1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    model(op, a, b, d, lat);
    @(posedge clk);
    #1;
    e.data = d;
    e.lat  = lat;
    e.cyc  = cycle_cnt;
    sb.push_back(e);
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
    @(negedge clk);
  endtask

  // Wait (bounded) until the scoreboard drains and the block is idle again
  task automatic waitIdle();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (sb.size() == 0 && req_ready) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL timeout: got %0d pending responses expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    bit          seen;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_a     = 32'h0;
    req_b     = 32'h0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    $display("[TB] checking reset state");
    checkOutput("rst_ready", {31'b0, req_ready}, 32'h1);
    checkOutput("rst_valid", {31'b0, rsp_valid}, 32'h0);
    checkOutput("rst_data", rsp_data, 32'h0);
    checkOutput("rst_busy", {31'b0, busy}, 32'h0);
    checkOutput("rst_alu_a", alu_a, 32'h0);
    checkOutput("rst_alu_b", alu_b, 32'h0);
    checkOutput("rst_alu_ctrl", {28'b0, alu_ctrl}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed requests");
    applyStimulus(2'b00, 32'd5, 32'd3);                 waitIdle();
    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF); waitIdle();
    applyStimulus(2'b00, 32'h1234_5678, 32'h0);         waitIdle();
    applyStimulus(2'b01, 32'd100, 32'd7);               waitIdle();
    applyStimulus(2'b10, 32'd100, 32'd7);               waitIdle();
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'h8000_0001); waitIdle();
    applyStimulus(2'b10, 32'hFFFF_FFFF, 32'h8000_0001); waitIdle();
    applyStimulus(2'b01, 32'd42, 32'd0);                waitIdle();
    applyStimulus(2'b10, 32'd42, 32'd0);                waitIdle();
    applyStimulus(2'b11, 32'd9, 32'd9);                 waitIdle();
    applyStimulus(2'b01, 32'd7, 32'd100);               waitIdle();
    applyStimulus(2'b00, 32'h8000_0001, 32'h8000_0000); waitIdle();
    applyStimulus(2'b01, 32'hDEAD_BEEF, 32'd1);         waitIdle();

    $display("[TB] random requests");
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      applyStimulus(2'($urandom_range(0, 2)), a, b);
      waitIdle();
    end

    $display("[TB] response held while rsp_ready is low");
    rsp_ready = 1'b0;
    applyStimulus(2'b00, 32'd7, 32'd6);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (rsp_valid) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL hold_wait: got no response expected rsp_valid");
      sb.delete();
    end
    repeat (5) begin
      @(negedge clk);
      checkOutput("hold_valid", {31'b0, rsp_valid}, 32'h1);
      checkOutput("hold_busy", {31'b0, busy}, 32'h1);
      checkOutput("hold_no_ready", {31'b0, req_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("after_pulse_ready", {31'b0, req_ready}, 32'h1);
    applyStimulus(2'b10, 32'd1000, 32'd33);
    rsp_ready = 1'b1;
    waitIdle();

    $display("[TB] reset in the middle of a divide");
    applyStimulus(2'b01, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    checkOutput("mid_busy", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    checkOutput("mid_rst_ready", {31'b0, req_ready}, 32'h1);
    checkOutput("mid_rst_busy", {31'b0, busy}, 32'h0);
    checkOutput("mid_rst_valid", {31'b0, rsp_valid}, 32'h0);
    checkOutput("mid_rst_alu_ctrl", {28'b0, alu_ctrl}, 32'h0);
    repeat (40) @(negedge clk);
    applyStimulus(2'b01, 32'd100, 32'd7);
    waitIdle();

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
